// File: rtl/countup_nbit_mod.sv
// rtl/countup_nbit_mod.sv - up/down modulo counter with clear, load, programmable terminal and wrap/saturate mode
module countup_nbit_mod #(
    parameter int WIDTH    = 3,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] D,
    input  logic             up,
    input  logic [WIDTH-1:0] last,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    logic [WIDTH-1:0] q_next;
    logic             wrap_next;
    logic             ovf_next;

    // The terminal check happens before stepping, so Q+1 / Q-1 never leave WIDTH bits.
    assign tc = up ? (Q >= last) : (Q == '0);

    always_comb begin
        q_next    = Q;
        wrap_next = 1'b0;
        ovf_next  = ovf;
        if (en) begin
            if (clr) begin
                q_next   = '0;
                ovf_next = 1'b0;
            end else if (ld) begin
                q_next = D;
            end else if (tc) begin
                wrap_next = 1'b1;
                ovf_next  = 1'b1;
                if (!SATURATE) begin
                    q_next = up ? '0 : last;
                end
            end else begin
                q_next = up ? (Q + WIDTH'(1)) : (Q - WIDTH'(1));
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Q    <= '0;
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            Q    <= q_next;
            wrap <= wrap_next;
            ovf  <= ovf_next;
        end
    end

endmodule

// File: tb/tb_countup_nbit_mod.sv
// tb/tb_countup_nbit_mod.sv - self-checking bench for countup_nbit_mod (3-bit wrap, 3-bit saturate, 8-bit wrap)
module tb_countup_nbit_mod;

    logic       clk = 1'b0;
    logic       rst, en, clr, ld, up;
    logic [2:0] d3, last3;
    logic [7:0] d8, last8;
    logic [2:0] q0, q1;
    logic [7:0] q2;
    logic       tc0, tc1, tc2, wrap0, wrap1, wrap2, ovf0, ovf1, ovf2;

    int vectors     = 0;
    int miscompares = 0;
    int mq[3], mw[3], mo[3];

    always #5 clk = ~clk;

    countup_nbit_mod #(.WIDTH(3), .SATURATE(1'b0)) u0 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .ld(ld), .D(d3), .up(up), .last(last3),
        .Q(q0), .tc(tc0), .wrap(wrap0), .ovf(ovf0));

    countup_nbit_mod #(.WIDTH(3), .SATURATE(1'b1)) u1 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .ld(ld), .D(d3), .up(up), .last(last3),
        .Q(q1), .tc(tc1), .wrap(wrap1), .ovf(ovf1));

    countup_nbit_mod #(.WIDTH(8), .SATURATE(1'b0)) u2 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .ld(ld), .D(d8), .up(up), .last(last8),
        .Q(q2), .tc(tc2), .wrap(wrap2), .ovf(ovf2));

    function automatic int lim(int i);
        return (i == 2) ? int'(last8) : int'(last3);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mq[i] = 0; mw[i] = 0; mo[i] = 0;
        end
    endtask

    // Behavioural reference: integer counter with range 0..last.
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            int l;
            int d;
            bit sat;
            l   = lim(i);
            d   = (i == 2) ? int'(d8) : int'(d3);
            sat = (i == 1);
            if (!rst) begin
                mq[i] = 0; mw[i] = 0; mo[i] = 0;
            end else if (!en) begin
                mw[i] = 0;
            end else if (clr) begin
                mq[i] = 0; mw[i] = 0; mo[i] = 0;
            end else if (ld) begin
                mq[i] = d; mw[i] = 0;
            end else if (up) begin
                if (mq[i] >= l) begin
                    mw[i] = 1; mo[i] = 1;
                    if (!sat) mq[i] = 0;
                end else begin
                    mq[i] = mq[i] + 1; mw[i] = 0;
                end
            end else begin
                if (mq[i] == 0) begin
                    mw[i] = 1; mo[i] = 1;
                    if (!sat) mq[i] = l;
                end else begin
                    mq[i] = mq[i] - 1; mw[i] = 0;
                end
            end
        end
    endtask

    task automatic cmp(string tag, int inst, string what, logic [7:0] obs, logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s u%0d.%s observed=%0d expected=%0d", tag, inst, what, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        logic [7:0] oq[3];
        logic       ow[3], oo[3], ot[3];
        oq[0] = {5'b0, q0}; oq[1] = {5'b0, q1}; oq[2] = q2;
        ow[0] = wrap0; ow[1] = wrap1; ow[2] = wrap2;
        oo[0] = ovf0;  oo[1] = ovf1;  oo[2] = ovf2;
        ot[0] = tc0;   ot[1] = tc1;   ot[2] = tc2;
        for (int i = 0; i < 3; i++) begin
            int etc;
            etc = up ? int'(mq[i] >= lim(i)) : int'(mq[i] == 0);
            cmp(tag, i, "Q",    oq[i], 8'(mq[i]));
            cmp(tag, i, "wrap", {7'b0, ow[i]}, 8'(mw[i]));
            cmp(tag, i, "ovf",  {7'b0, oo[i]}, 8'(mo[i]));
            cmp(tag, i, "tc",   {7'b0, ot[i]}, 8'(etc));
        end
    endtask

    task automatic step(string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; ld = 1'b0; up = 1'b1;
        d3 = 3'd0; last3 = 3'd7; d8 = 8'd0; last8 = 8'd255;
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;

        for (int k = 0; k < 9; k++) step("wrap_run");

        clr = 1'b1; step("clr"); clr = 1'b0;
        last3 = 3'd4;
        for (int k = 0; k < 6; k++) step("modulo_up");
        up = 1'b0;
        for (int k = 0; k < 3; k++) step("modulo_down");

        last3 = 3'd0; up = 1'b1;
        for (int k = 0; k < 3; k++) step("last0_up");
        up = 1'b0;
        for (int k = 0; k < 2; k++) step("last0_down");

        clr = 1'b1; step("clr"); clr = 1'b0;
        last3 = 3'd5; up = 1'b1;
        for (int k = 0; k < 7; k++) step("sat_up");
        clr = 1'b1; step("clr"); clr = 1'b0;
        up = 1'b0;
        for (int k = 0; k < 2; k++) step("sat_down0");

        clr = 1'b1; ld = 1'b1; d3 = 3'd6; d8 = 8'd6; step("clr_ld");
        clr = 1'b0; en = 1'b0; step("ld_gated");
        en = 1'b1; step("ld");
        ld = 1'b0; last3 = 3'd3; up = 1'b1; step("above_last");

        d8 = 8'd254; last8 = 8'd255; ld = 1'b1; step("w8_ld");
        ld = 1'b0;
        for (int k = 0; k < 2; k++) step("w8_up");
        clr = 1'b1; step("clr"); clr = 1'b0;
        up = 1'b0; step("w8_down0");

        up = 1'b1; last3 = 3'd0; step("mk_ovf");
        last3 = 3'd7;
        for (int k = 0; k < 5; k++) step("to5");
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        for (int k = 0; k < 2; k++) step("rst_held_en");
        en = 1'b0; step("rst_held_dis");
        @(negedge clk);
        rst = 1'b1; en = 1'b1;

        for (int k = 0; k < 300; k++) begin
            en    = ($urandom_range(0, 9) != 0);
            clr   = ($urandom_range(0, 19) == 0);
            ld    = ($urandom_range(0, 9) == 0);
            up    = ($urandom_range(0, 3) != 0);
            d3    = 3'($urandom);
            d8    = 8'($urandom);
            if ($urandom_range(0, 7) == 0) last3 = 3'($urandom);
            if ($urandom_range(0, 7) == 0) last8 = 8'($urandom_range(0, 20));
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
